wb_timer: RTL



---
 rtl/wb_timer_pkg.sv | 27 ++
 rtl/wb_timer_prescaler.sv | 35 +++
 rtl/wb_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// ============================================================================
// Module : wb_timer_pkg
// Brief  : Register map and bit positions shared by the wb_timer sources.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_timer_pkg;

    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_PRESCALE = 1;
    localparam int ADDR_COUNT    = 2;
    localparam int ADDR_COMPARE  = 3;
    localparam int ADDR_STATUS   = 4;
    localparam int ADDR_CAPTURE  = 5;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_W          = 3;

    localparam int ST_MATCH    = 0;
    localparam int ST_CAPTURED = 1;

endpackage

`default_nettype wire

// File: rtl/wb_timer_prescaler.sv
// ============================================================================
// Module : wb_timer_prescaler
// Brief  : Counts 0..prescale while enabled and emits a one-cycle tick at the top.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_at_top;

    assign w_at_top = (r_cnt == i_prescale);
    assign o_tick   = i_en & w_at_top;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_top ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_timer.sv
// ============================================================================
// Module : wb_timer
// Brief  : Wishbone B4 pipelined 32-bit compare timer with prescaler and level
//          IRQ. Define WB_TIMER_CAPTURE_EN to build the i_capture timestamp path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int PRESCALE_W = 16
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic [31:0]       o_wb_data,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    input  logic              i_capture,
    output logic              o_irq
);

    logic                  w_acc;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_prescale;
    logic                  w_wr_count;
    logic                  w_wr_compare;
    logic                  w_wr_status;
    logic                  w_tick;
    logic                  w_match_set;
    logic [31:0]           w_rdata;
    logic [31:0]           w_capture;
    logic                  w_captured;

    logic [CTRL_W-1:0]     r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_match;
    logic                  r_ack;
    logic [31:0]           r_rdata;

    assign w_acc         = i_wb_cyc & i_wb_stb;
    assign w_wr          = w_acc & i_wb_we;
    assign w_wr_ctrl     = w_wr && (i_wb_addr == ADDR_W'(ADDR_CTRL));
    assign w_wr_prescale = w_wr && (i_wb_addr == ADDR_W'(ADDR_PRESCALE));
    assign w_wr_count    = w_wr && (i_wb_addr == ADDR_W'(ADDR_COUNT));
    assign w_wr_compare  = w_wr && (i_wb_addr == ADDR_W'(ADDR_COMPARE));
    assign w_wr_status   = w_wr && (i_wb_addr == ADDR_W'(ADDR_STATUS));

    wb_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (i_wb_clk),
        .rst        (i_wb_rst),
        .i_en       (r_ctrl[CTRL_EN]),
        .i_clr      (w_wr_count | w_wr_prescale),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // A COUNT write in the same cycle swallows the tick, including its match.
    assign w_match_set = w_tick & ~w_wr_count & (r_count == r_compare);

    always_comb begin
        w_rdata = '0;
        case (i_wb_addr)
            ADDR_W'(ADDR_CTRL):     w_rdata[CTRL_W-1:0]     = r_ctrl;
            ADDR_W'(ADDR_PRESCALE): w_rdata[PRESCALE_W-1:0] = r_prescale;
            ADDR_W'(ADDR_COUNT):    w_rdata                 = r_count;
            ADDR_W'(ADDR_COMPARE):  w_rdata                 = r_compare;
            ADDR_W'(ADDR_STATUS): begin
                w_rdata[ST_MATCH]    = r_match;
                w_rdata[ST_CAPTURED] = w_captured;
            end
            ADDR_W'(ADDR_CAPTURE):  w_rdata                 = w_capture;
            default:                w_rdata                 = '0;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= (w_acc && !i_wb_we) ? w_rdata : '0;
            if (w_wr_ctrl)     r_ctrl     <= i_wb_data[CTRL_W-1:0];
            if (w_wr_prescale) r_prescale <= i_wb_data[PRESCALE_W-1:0];
            if (w_wr_compare)  r_compare  <= i_wb_data;
            if (w_wr_count) begin
                r_count <= i_wb_data;
            end else if (w_tick) begin
                r_count <= (w_match_set && r_ctrl[CTRL_AUTORELOAD]) ? '0 : r_count + 32'd1;
            end
            // Set has priority over a simultaneous write-1-to-clear.
            r_match <= (r_match & ~(w_wr_status & i_wb_data[ST_MATCH])) | w_match_set;
        end
    end

`ifdef WB_TIMER_CAPTURE_EN
    logic [2:0]  r_cap_sync;
    logic [31:0] r_capture;
    logic        r_captured;
    logic        w_cap_edge;

    // Two synchronizer stages plus one history bit for rising-edge detection.
    assign w_cap_edge = r_cap_sync[1] & ~r_cap_sync[2];

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_cap_sync <= '0;
            r_capture  <= '0;
            r_captured <= 1'b0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], i_capture};
            if (w_cap_edge) r_capture <= r_count;
            r_captured <= (r_captured & ~(w_wr_status & i_wb_data[ST_CAPTURED])) | w_cap_edge;
        end
    end

    assign w_capture  = r_capture;
    assign w_captured = r_captured;
`else
    logic w_unused_capture;
    assign w_unused_capture = i_capture;
    assign w_capture        = '0;
    assign w_captured       = 1'b0;
`endif

    // Dropping cyc or asserting reset abandons an ack still in flight.
    assign o_wb_ack   = r_ack & i_wb_cyc & ~i_wb_rst;
    assign o_wb_data  = o_wb_ack ? r_rdata : '0;
    assign o_wb_stall = 1'b0;
    assign o_irq      = r_match & r_ctrl[CTRL_IRQ_EN];

endmodule

`default_nettype wire
